// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and constants for the elevator keypad scan controller.
package keypad_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2
  } scan_state_t;

  localparam int KP_ROWS    = 4;
  localparam int KP_COLS    = 4;
  localparam int KEY_CODE_W = 4;

  function automatic logic [KP_COLS-1:0] col_onehot(input logic [1:0] idx);
    col_onehot = 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key-code valid/ready handshake between the scan controller and the request queue.
interface keypad_scan_ctrl_if;
  logic                             key_valid;
  logic [keypad_pkg::KEY_CODE_W-1:0] key_code;
  logic                             key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl_prio_enc4.sv
// Lowest-set-bit encoder with any/multi flags, used to pick one new press per cycle.
module prio_enc4 (
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       any,
  output logic       multi
);
  // pick the lowest requesting row
  always_comb begin
    idx = 2'd0;
    if (req[0]) begin
      idx = 2'd0;
    end else if (req[1]) begin
      idx = 2'd1;
    end else if (req[2]) begin
      idx = 2'd2;
    end else if (req[3]) begin
      idx = 2'd3;
    end else begin
      idx = 2'd0;
    end
  end

  assign any   = |req;
  assign multi = (req & (req - 4'd1)) != 4'd0;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scan sequencer with debouncer gating and de-duplicated key-code delivery.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_en,
  input  logic [KP_ROWS-1:0]  row,
  input  logic [KP_ROWS-1:0]  deb_pulse,
  output logic                deb_en,
  output logic [KP_COLS-1:0]  col,
  keypad_scan_ctrl_if.master  key,
  output logic                drop,
  input  logic                drop_clr
);
  scan_state_t state_r, state_s;
  logic [15:0]           cnt_r, cnt_s;
  logic [1:0]            col_idx_r, col_idx_s;
  logic [15:0]           held_r, held_s;
  logic                  valid_r, valid_s;
  logic [KEY_CODE_W-1:0] code_r, code_s;
  logic                  drop_r, drop_s;
  logic [KP_COLS-1:0]    col_r, col_s;
  logic                  deb_en_r, deb_en_s;

  logic [KP_ROWS-1:0] held_col_s;
  logic [KP_ROWS-1:0] new_press_s;
  logic [1:0]         win_idx_s;
  logic               win_any_s;
  logic               win_multi_s;
  logic               sampling_s;
  logic               last_sample_s;
  logic               accept_s;
  logic               set_drop_s;

  assign held_col_s    = held_r[{col_idx_r, 2'b00} +: 4];
  assign sampling_s    = (state_r == SAMPLE) && scan_en;
  assign last_sample_s = sampling_s && (cnt_r == 16'(SAMPLE_CYCLES - 1));
  assign new_press_s   = sampling_s ? (deb_pulse & ~held_col_s) : 4'b0000;
  assign accept_s      = valid_r && key.key_ready;

  prio_enc4 u_prio (
    .req   (new_press_s),
    .idx   (win_idx_s),
    .any   (win_any_s),
    .multi (win_multi_s)
  );

  // state, phase counter and column index sequencing
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    col_idx_s = col_idx_r;
    if (!scan_en) begin
      state_s   = IDLE;
      cnt_s     = 16'd0;
      col_idx_s = 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s   = DRIVE;
          cnt_s     = 16'd0;
          col_idx_s = 2'd0;
        end
        DRIVE: begin
          if (cnt_r == 16'(SETTLE_CYCLES - 1)) begin
            state_s = SAMPLE;
            cnt_s   = 16'd0;
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
        end
        SAMPLE: begin
          if (last_sample_s) begin
            state_s   = DRIVE;
            cnt_s     = 16'd0;
            col_idx_s = col_idx_r + 2'd1;
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
        end
        default: begin
          state_s   = IDLE;
          cnt_s     = 16'd0;
          col_idx_s = 2'd0;
        end
      endcase
    end
  end

  // held map, output slot, drop flag and next column drive
  always_comb begin
    held_s     = held_r;
    valid_s    = valid_r && !accept_s;
    code_s     = code_r;
    set_drop_s = win_multi_s;
    if (!scan_en || (state_r == IDLE)) begin
      held_s = 16'd0;
    end else if (sampling_s) begin
      // pulsed rows become held; on the last cycle unpressed, unpulsed rows release
      if (last_sample_s) begin
        held_s[{col_idx_r, 2'b00} +: 4] = (held_col_s & row) | deb_pulse;
      end else begin
        held_s[{col_idx_r, 2'b00} +: 4] = held_col_s | deb_pulse;
      end
    end else begin
      held_s = held_r;
    end

    if (win_any_s) begin
      if (!valid_r || accept_s) begin
        valid_s = 1'b1;
        code_s  = {col_idx_r, win_idx_s};
      end else begin
        set_drop_s = 1'b1;
      end
    end else begin
      code_s = code_r;
    end

    if (set_drop_s) begin
      drop_s = 1'b1;
    end else if (drop_clr) begin
      drop_s = 1'b0;
    end else begin
      drop_s = drop_r;
    end

    if (state_s == IDLE) begin
      col_s = 4'b0000;
    end else begin
      col_s = col_onehot(col_idx_s);
    end
    deb_en_s = (state_s == SAMPLE);
  end

  // all state and outputs registered, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= 16'd0;
      col_idx_r <= 2'd0;
      held_r    <= 16'd0;
      valid_r   <= 1'b0;
      code_r    <= 4'd0;
      drop_r    <= 1'b0;
      col_r     <= 4'b0000;
      deb_en_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      col_idx_r <= col_idx_s;
      held_r    <= held_s;
      valid_r   <= valid_s;
      code_r    <= code_s;
      drop_r    <= drop_s;
      col_r     <= col_s;
      deb_en_r  <= deb_en_s;
    end
  end

  assign col          = col_r;
  assign deb_en       = deb_en_r;
  assign drop         = drop_r;
  assign key.key_valid = valid_r;
  assign key.key_code  = code_r;
endmodule
